// File: rtl/frame_sequencer_if.sv
// Bundle between the register file, the frame sequencer and the pixel
// sampling block: configuration and strobes in, sampling controls and
// status out.
interface frame_sequencer_if #(
    parameter int CNT_W = 16
);
    // Control strobes and configuration from the register file
    logic             start;
    logic             abort;
    logic [7:0]       cfg_num_frames;
    logic [CNT_W-1:0] cfg_settle_cycles;
    logic [CNT_W-1:0] cfg_sample_cycles;
    logic [CNT_W-1:0] cfg_gap_cycles;
    logic             cfg_cds;
    logic             cfg_single_pixel;
    logic [7:0]       cfg_row_addr;
    logic [7:0]       cfg_col_addr;

    // Controls toward the sampling block
    logic             vg;
    logic             sample_en;
    logic             single_pixel_en;
    logic             correlated_double_sampling;
    logic [7:0]       single_pixel_row_addr;
    logic [7:0]       single_pixel_col_addr;

    // Status back to the register file
    logic             busy;
    logic             frame_done;
    logic [7:0]       frame_count;
    logic             seq_done;
    logic             aborted;
    logic             cfg_err;

    // Register-file / stimulus side
    modport master (
        output start, abort, cfg_num_frames, cfg_settle_cycles,
               cfg_sample_cycles, cfg_gap_cycles, cfg_cds,
               cfg_single_pixel, cfg_row_addr, cfg_col_addr,
        input  vg, sample_en, single_pixel_en, correlated_double_sampling,
               single_pixel_row_addr, single_pixel_col_addr,
               busy, frame_done, frame_count, seq_done, aborted, cfg_err
    );

    // Sequencer side
    modport slave (
        input  start, abort, cfg_num_frames, cfg_settle_cycles,
               cfg_sample_cycles, cfg_gap_cycles, cfg_cds,
               cfg_single_pixel, cfg_row_addr, cfg_col_addr,
        output vg, sample_en, single_pixel_en, correlated_double_sampling,
               single_pixel_row_addr, single_pixel_col_addr,
               busy, frame_done, frame_count, seq_done, aborted, cfg_err
    );
endinterface

// File: rtl/frame_sequencer.sv
// Frame sequencer: walks the pixel sampling block through VG settle,
// sample window, VG hold-off and inter-frame gap for a fixed number of
// frames or continuously, with an orderly abort path that keeps VG up
// for the hold-off time after sampling stops.
module frame_sequencer #(
    parameter int PIXEL_NUM_ROW = 7,
    parameter int PIXEL_NUM_COL = 16,
    parameter int CNT_W         = 16,
    parameter int VG_HOLD       = 5
) (
    input  logic              clk,
    input  logic              reset,
    frame_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETTLE   = 3'd1,
        S_SAMPLE   = 3'd2,
        S_HOLD     = 3'd3,
        S_GAP      = 3'd4,
        S_SHUTDOWN = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LEN_M1 = CNT_W'(VG_HOLD - 1);

    // Counter reload for a phase of 'len' cycles; zero-length phases last one cycle
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : (len - CNT_ONE);
    endfunction

    // Sequence state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       frame_count_q, frame_count_d;

    // Configuration captured at start
    logic [7:0]       num_frames_q, num_frames_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] sample_q, sample_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             cds_q, cds_d;
    logic             single_q, single_d;
    logic [7:0]       row_q, row_d;
    logic [7:0]       col_q, col_d;

    // Registered outputs
    logic vg_q, vg_d;
    logic sample_en_q, sample_en_d;
    logic spe_q, spe_d;
    logic cds_out_q, cds_out_d;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;
    logic seq_done_q, seq_done_d;
    logic aborted_q, aborted_d;
    logic cfg_err_q, cfg_err_d;

    logic latch_cfg;
    logic cfg_valid;
    logic last_frame;

    // Configuration check on the incoming (not yet latched) values
    always_comb begin
        cfg_valid = (bus.cfg_sample_cycles != '0);
        if (bus.cfg_single_pixel &&
            ((int'(bus.cfg_row_addr) >= PIXEL_NUM_ROW) ||
             (int'(bus.cfg_col_addr) >= PIXEL_NUM_COL)))
            cfg_valid = 1'b0;
    end

    // Next state, phase counter, frame count and status pulses
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        frame_count_d = frame_count_q;
        latch_cfg     = 1'b0;
        frame_done_d  = 1'b0;
        seq_done_d    = 1'b0;
        aborted_d     = 1'b0;
        cfg_err_d     = 1'b0;
        last_frame    = (num_frames_q != 8'd0) &&
                        (({1'b0, frame_count_q} + 9'd1) == {1'b0, num_frames_q});

        case (state_q)
            S_IDLE: begin
                // abort beats a simultaneous start
                if (bus.start && !bus.abort) begin
                    latch_cfg = 1'b1;
                    if (cfg_valid) begin
                        state_d       = S_SETTLE;
                        cnt_d         = len_m1(bus.cfg_settle_cycles);
                        frame_count_d = 8'd0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    state_d = S_SHUTDOWN;
                    cnt_d   = HOLD_LEN_M1;
                end else if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                    cnt_d   = len_m1(sample_q);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_SAMPLE: begin
                if (bus.abort) begin
                    state_d = S_SHUTDOWN;
                    cnt_d   = HOLD_LEN_M1;
                end else if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LEN_M1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_HOLD: begin
                if (bus.abort) begin
                    state_d = S_SHUTDOWN;
                    cnt_d   = HOLD_LEN_M1;
                end else if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = len_m1(gap_q);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                // VG is already low here, so abort goes straight home
                if (bus.abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_q == '0) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = (frame_count_q == 8'hFF) ? 8'hFF
                                                             : frame_count_q + 8'd1;
                    if (last_frame) begin
                        state_d    = S_IDLE;
                        seq_done_d = 1'b1;
                    end else begin
                        state_d = S_SETTLE;
                        cnt_d   = len_m1(settle_q);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_SHUTDOWN: begin
                if (cnt_q == '0) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Configuration capture and output decode from the next state
    always_comb begin
        num_frames_d = latch_cfg ? bus.cfg_num_frames    : num_frames_q;
        settle_d     = latch_cfg ? bus.cfg_settle_cycles : settle_q;
        sample_d     = latch_cfg ? bus.cfg_sample_cycles : sample_q;
        gap_d        = latch_cfg ? bus.cfg_gap_cycles    : gap_q;
        cds_d        = latch_cfg ? bus.cfg_cds           : cds_q;
        single_d     = latch_cfg ? bus.cfg_single_pixel  : single_q;
        row_d        = latch_cfg ? bus.cfg_row_addr      : row_q;
        col_d        = latch_cfg ? bus.cfg_col_addr      : col_q;

        vg_d        = (state_d == S_SETTLE) || (state_d == S_SAMPLE) ||
                      (state_d == S_HOLD)   || (state_d == S_SHUTDOWN);
        sample_en_d = (state_d == S_SAMPLE);
        cds_out_d   = ((state_d == S_SETTLE) || (state_d == S_SAMPLE)) && cds_d;
        spe_d       = ((state_d == S_SETTLE) || (state_d == S_SAMPLE) ||
                       (state_d == S_HOLD)) && single_d;
        busy_d      = (state_d != S_IDLE);
    end

    // State, counter and frame count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Latched configuration and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            num_frames_q <= 8'd0;
            settle_q     <= '0;
            sample_q     <= '0;
            gap_q        <= '0;
            cds_q        <= 1'b0;
            single_q     <= 1'b0;
            row_q        <= 8'd0;
            col_q        <= 8'd0;
            vg_q         <= 1'b0;
            sample_en_q  <= 1'b0;
            spe_q        <= 1'b0;
            cds_out_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            seq_done_q   <= 1'b0;
            aborted_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            num_frames_q <= num_frames_d;
            settle_q     <= settle_d;
            sample_q     <= sample_d;
            gap_q        <= gap_d;
            cds_q        <= cds_d;
            single_q     <= single_d;
            row_q        <= row_d;
            col_q        <= col_d;
            vg_q         <= vg_d;
            sample_en_q  <= sample_en_d;
            spe_q        <= spe_d;
            cds_out_q    <= cds_out_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            seq_done_q   <= seq_done_d;
            aborted_q    <= aborted_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign bus.vg                         = vg_q;
    assign bus.sample_en                  = sample_en_q;
    assign bus.single_pixel_en            = spe_q;
    assign bus.correlated_double_sampling = cds_out_q;
    assign bus.single_pixel_row_addr      = row_q;
    assign bus.single_pixel_col_addr      = col_q;
    assign bus.busy                       = busy_q;
    assign bus.frame_done                 = frame_done_q;
    assign bus.frame_count                = frame_count_q;
    assign bus.seq_done                   = seq_done_q;
    assign bus.aborted                    = aborted_q;
    assign bus.cfg_err                    = cfg_err_q;

endmodule
